// File: rtl/nn_eval_ctrl.sv
// Evaluation sequencer for a stochastic node array: clears burst memories, warms up the
// stream generators, then counts ones on each node output over a programmable length.
module nn_eval_ctrl #(
    parameter int NOUT     = 3,
    parameter int CNT_W    = 8,
    parameter int INIT_CYC = 2,
    parameter int WARMUP   = 6
) (
    input  logic                        CLK,
    input  logic                        INIT,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_W-1:0]            stream_len,
    input  logic [NOUT-1:0]             a_in,
    output logic                        node_init,
    output logic                        run,
    output logic                        busy,
    output logic                        done,
    output logic [NOUT*(CNT_W+1)-1:0]   result
);

    localparam int RW  = CNT_W + 1;
    localparam int PW0 = (RW > $clog2(INIT_CYC + 1)) ? RW : $clog2(INIT_CYC + 1);
    localparam int PW  = (PW0 > $clog2(WARMUP + 1)) ? PW0 : $clog2(WARMUP + 1);

    localparam logic [PW-1:0] ONE       = PW'(1);
    localparam logic [PW-1:0] INIT_LAST = PW'(INIT_CYC - 1);
    localparam logic [PW-1:0] WARM_LAST = PW'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARM,
        S_COUNT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             phase_q, phase_d;
    logic [CNT_W-1:0]          len_q, len_d;
    logic [RW-1:0]             cnt_q [NOUT];
    logic [RW-1:0]             cnt_d [NOUT];
    logic [NOUT*RW-1:0]        result_q, result_d;
    logic                      node_init_q, node_init_d;
    logic                      run_q, run_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [RW-1:0]             len_full;
    logic [PW-1:0]             count_last;

    // A latched length of zero stands for 2^CNT_W, which needs the extra top bit.
    assign len_full   = {(len_q == '0), len_q};
    assign count_last = PW'(len_full - RW'(1));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                for (int i = 0; i < NOUT; i++) cnt_d[i] = '0;
                if (start && !abort) begin
                    len_d   = stream_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_q == INIT_LAST) begin
                    phase_d = '0;
                    state_d = (WARMUP == 0) ? S_COUNT : S_WARM;
                end else begin
                    phase_d = phase_q + ONE;
                end
            end
            S_WARM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_q == WARM_LAST) begin
                    phase_d = '0;
                    state_d = S_COUNT;
                end else begin
                    phase_d = phase_q + ONE;
                end
            end
            S_COUNT: begin
                for (int i = 0; i < NOUT; i++) cnt_d[i] = cnt_q[i] + RW'(a_in[i]);
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_q == count_last) begin
                    state_d = S_DONE;
                    for (int i = 0; i < NOUT; i++) result_d[i*RW +: RW] = cnt_d[i];
                end else begin
                    phase_d = phase_q + ONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are flops aligned with the state.
        node_init_d = (state_d == S_CLEAR);
        run_d       = (state_d == S_WARM) || (state_d == S_COUNT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            len_q       <= '0;
            for (int i = 0; i < NOUT; i++) cnt_q[i] <= '0;
            result_q    <= '0;
            node_init_q <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            len_q       <= len_d;
            for (int i = 0; i < NOUT; i++) cnt_q[i] <= cnt_d[i];
            result_q    <= result_d;
            node_init_q <= node_init_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign node_init = node_init_q;
    assign run       = run_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule
